// File: rtl/pattern_pkg.sv
// Shared types and helpers for the pattern hit counter: FSM state encoding and a
// saturating increment used by the hit accumulator.
package pattern_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        COUNT  = 2'd1,
        REPORT = 2'd2
    } state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                            input logic        inc,
                                            input logic [31:0] max_val);
        if (inc && (val < max_val)) begin
            return val + 32'd1;
        end
        return val;
    endfunction

endpackage

// File: rtl/pattern_win_timer.sv
// Window position timer: counts window cycles 0..WIN_LEN-1 while running and wraps to 0
// after the last one, so back-to-back windows need no extra restart cycle.
module pattern_win_timer #(
    parameter int WIN_LEN = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear_i,
    input  logic run_i,
    output logic last_o
);

    localparam int WIN_W = $clog2(WIN_LEN);
    localparam logic [WIN_W-1:0] LAST_POS = WIN_W'(WIN_LEN - 1);

    logic [WIN_W-1:0] win_cnt;

    assign last_o = (win_cnt == LAST_POS);

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            win_cnt <= '0;
        end else if (clear_i) begin
            win_cnt <= '0;
        end else if (run_i) begin
            win_cnt <= last_o ? '0 : win_cnt + WIN_W'(1);
        end
    end

endmodule

// File: rtl/pattern_hit_counter.sv
// Counts detector hits over fixed WIN_LEN-cycle windows and presents each window result
// with a threshold alarm on a valid/ready port. Build option PATTERN_HIT_CNT_BACK2BACK_EN
// removes the REPORT gap so windows run back to back while a result awaits its handshake.
//
// state  | meaning
// IDLE   | waiting for en_i; hits ignored
// COUNT  | accumulating hits over the current window
// REPORT | result held until accepted; hits here are lost
module pattern_hit_counter
    import pattern_pkg::*;
#(
    parameter int CNT_W   = 8,
    parameter int WIN_LEN = 16,
    parameter int THRESH  = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en_i,
    input  logic             hit_i,
    output logic [CNT_W-1:0] cnt_o,
    output logic             cnt_valid,
    input  logic             cnt_ready,
    output logic             alarm_o,
    output logic             lost_o
);

    localparam logic [31:0] CNT_MAX  = (32'd1 << CNT_W) - 32'd1;
    localparam logic [31:0] THRESH_U = 32'(THRESH);

    state_t           state;
    state_t           state_nxt;
    logic             win_last;
    logic             count_run;
    logic             win_done;
    logic             load;
    logic             lost_set;
    logic             handshake;
    logic             alarm_q;
    logic [CNT_W-1:0] hit_cnt;
    logic [CNT_W-1:0] hit_sum;

    assign handshake = cnt_valid & cnt_ready;
    assign hit_sum   = CNT_W'(sat_inc(32'(hit_cnt), hit_i, CNT_MAX));
    assign alarm_o   = alarm_q & cnt_valid;

    pattern_win_timer #(
        .WIN_LEN (WIN_LEN)
    ) u_win_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear_i (!count_run),
        .run_i   (count_run),
        .last_o  (win_last)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (en_i) state_nxt = COUNT;
            end
            COUNT: begin
                if (!en_i) begin
                    state_nxt = IDLE;
                end
`ifndef PATTERN_HIT_CNT_BACK2BACK_EN
                else if (win_last) begin
                    state_nxt = REPORT;
                end
`endif
            end
            REPORT: begin
                if (handshake) state_nxt = en_i ? COUNT : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        count_run = (state == COUNT) && en_i;
        win_done  = count_run && win_last;
`ifdef PATTERN_HIT_CNT_BACK2BACK_EN
        // A finished window only overwrites the held result if it leaves this cycle.
        load      = win_done && (!cnt_valid || cnt_ready);
        lost_set  = win_done && cnt_valid && !cnt_ready;
`else
        load      = win_done;
        lost_set  = (state == REPORT) && hit_i;
`endif
    end

    always_ff @(posedge clk) begin
        if (!reset_n || !count_run || win_done) begin
            hit_cnt <= '0;
        end else begin
            hit_cnt <= hit_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            cnt_o     <= '0;
            cnt_valid <= 1'b0;
            alarm_q   <= 1'b0;
            lost_o    <= 1'b0;
        end else begin
            if (load) begin
                cnt_o     <= hit_sum;
                alarm_q   <= (32'(hit_sum) >= THRESH_U);
                cnt_valid <= 1'b1;
            end else if (handshake) begin
                cnt_valid <= 1'b0;
            end
            if (lost_set) begin
                lost_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pattern_hit_counter.sv
// Bench for pattern_hit_counter: directed scenarios followed by random traffic, all
// compared cycle by cycle against a window-level reference model.
module tb_pattern_hit_counter;

    localparam int WIN_LEN = 16;
    localparam int THRESH  = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       en_i = 1'b0;
    logic       hit_i = 1'b0;
    logic       cnt_ready = 1'b0;
    logic [7:0] cnt_o;
    logic       cnt_valid;
    logic       alarm_o;
    logic       lost_o;
    logic [2:0] cnt3_o;
    logic       cnt3_valid;
    logic       alarm3_o;
    logic       lost3_o;

    int vectors = 0;
    int miscompares = 0;

    // Reference model: phase 0 idle, 1 inside a window, 2 holding a result (gap build only)
    int m_phase, m_pos, m_hits, m_cnt8, m_cnt3;
    bit m_valid, m_alarm8, m_alarm3, m_lost;

    always #5 clk = ~clk;

    pattern_hit_counter #(.CNT_W(8), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut (
        .clk(clk), .reset_n(reset_n), .en_i(en_i), .hit_i(hit_i),
        .cnt_o(cnt_o), .cnt_valid(cnt_valid), .cnt_ready(cnt_ready),
        .alarm_o(alarm_o), .lost_o(lost_o)
    );

    pattern_hit_counter #(.CNT_W(3), .WIN_LEN(WIN_LEN), .THRESH(THRESH)) dut_sat (
        .clk(clk), .reset_n(reset_n), .en_i(en_i), .hit_i(hit_i),
        .cnt_o(cnt3_o), .cnt_valid(cnt3_valid), .cnt_ready(cnt_ready),
        .alarm_o(alarm3_o), .lost_o(lost3_o)
    );

    function automatic int min_int(input int a, input int b);
        return (a < b) ? a : b;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = 0; m_pos = 0; m_hits = 0;
        m_valid = 0; m_cnt8 = 0; m_cnt3 = 0;
        m_alarm8 = 0; m_alarm3 = 0; m_lost = 0;
    endtask

    task automatic model_step(input bit en, input bit hit, input bit rdy, input bit rst);
        bit hs;
        bit load;
        if (!rst) begin
            model_reset();
            return;
        end
        hs   = m_valid && rdy;
        load = 0;
        case (m_phase)
            0: if (en) begin m_phase = 1; m_pos = 0; m_hits = 0; end
            1: begin
                if (!en) begin
                    m_phase = 0;
                end else begin
                    m_hits += int'(hit);
                    if (m_pos == WIN_LEN - 1) begin
`ifdef PATTERN_HIT_CNT_BACK2BACK_EN
                        if (!m_valid || rdy) load = 1;
                        else m_lost = 1;
                        m_pos = 0;
`else
                        load = 1;
                        m_phase = 2;
`endif
                    end else begin
                        m_pos++;
                    end
                end
            end
            default: begin
                if (hit) m_lost = 1;
                if (hs) begin m_phase = en ? 1 : 0; m_pos = 0; m_hits = 0; end
            end
        endcase
        if (load) begin
            m_cnt8   = min_int(m_hits, 255);
            m_cnt3   = min_int(m_hits, 7);
            m_alarm8 = (m_cnt8 >= THRESH);
            m_alarm3 = (m_cnt3 >= THRESH);
            m_valid  = 1;
            if (m_phase == 1) m_hits = 0;
        end else if (hs) begin
            m_valid = 0;
        end
    endtask

    task automatic step(input bit en, input bit hit, input bit rdy, input bit rst);
        en_i = en; hit_i = hit; cnt_ready = rdy; reset_n = rst;
        @(posedge clk);
        #1;
        model_step(en, hit, rdy, rst);
        check("cnt_valid", 32'(cnt_valid), 32'(m_valid));
        check("cnt_o", 32'(cnt_o), 32'(m_cnt8));
        check("alarm_o", 32'(alarm_o), 32'(m_alarm8 & m_valid));
        check("lost_o", 32'(lost_o), 32'(m_lost));
        check("sat_cnt_o", 32'(cnt3_o), 32'(m_cnt3));
        check("sat_alarm_o", 32'(alarm3_o), 32'(m_alarm3 & m_valid));
    endtask

    initial begin
        model_reset();

        // reset held with en/hit active
        step(1, 1, 1, 0);
        step(1, 1, 1, 0);
        check("rst_valid", 32'(cnt_valid), 32'd0);
        check("rst_cnt", 32'(cnt_o), 32'd0);
        check("rst_alarm", 32'(alarm_o), 32'd0);
        check("rst_lost", 32'(lost_o), 32'd0);
        step(0, 0, 1, 1);

        // hits on window cycles 2,5,9
        step(1, 0, 1, 1);
        for (int i = 0; i < WIN_LEN; i++) step(1, (i == 2 || i == 5 || i == 9), 1, 1);
        check("t2_valid", 32'(cnt_valid), 32'd1);
        check("t2_cnt", 32'(cnt_o), 32'd3);
        check("t2_alarm", 32'(alarm_o), 32'd0);
        step(0, 0, 1, 1);
        check("t2_valid_drop", 32'(cnt_valid), 32'd0);

        // every cycle a hit: 8-bit sees 16, 3-bit saturates at 7
        step(1, 0, 1, 1);
        for (int i = 0; i < WIN_LEN; i++) step(1, 1, 1, 1);
        check("t3_cnt", 32'(cnt_o), 32'd16);
        check("t3_sat_cnt", 32'(cnt3_o), 32'd7);
        check("t3_sat_alarm", 32'(alarm3_o), 32'd1);
        step(0, 0, 1, 1);

        // result held with consumer stalled, hit arrives while waiting
        step(1, 0, 0, 1);
        for (int i = 0; i < WIN_LEN; i++) step(1, (i == 3), 0, 1);
        check("t4_valid", 32'(cnt_valid), 32'd1);
        for (int k = 0; k < 10; k++) begin
            step(1, (k == 4), 0, 1);
            check("t4_hold_cnt", 32'(cnt_o), 32'd1);
        end
`ifdef PATTERN_HIT_CNT_BACK2BACK_EN
        check("t4_lost", 32'(lost_o), 32'd0);
`else
        check("t4_lost", 32'(lost_o), 32'd1);
`endif
        step(0, 0, 1, 1);
        step(0, 0, 1, 0);
        step(0, 0, 1, 1);

        // abort at window cycle 8, then a full restart
        step(1, 0, 1, 1);
        for (int i = 0; i < 8; i++) step(1, (i == 1), 1, 1);
        step(0, 1, 1, 1);
        check("t5_no_valid", 32'(cnt_valid), 32'd0);
        step(0, 1, 1, 1);
        step(0, 1, 1, 1);
        check("t5_idle_lost", 32'(lost_o), 32'd0);
        step(1, 0, 0, 1);
        for (int i = 0; i < WIN_LEN - 1; i++) step(1, (i % 4 == 0), 0, 1);
        check("t5_not_yet", 32'(cnt_valid), 32'd0);
        step(1, 1, 0, 1);
        check("t5_valid", 32'(cnt_valid), 32'd1);
        check("t5_cnt", 32'(cnt_o), 32'd5);
        check("t5_alarm", 32'(alarm_o), 32'd1);

        // reset while a result is pending
        step(1, 0, 0, 0);
        check("t6_valid", 32'(cnt_valid), 32'd0);
        check("t6_cnt", 32'(cnt_o), 32'd0);
        step(0, 0, 0, 1);

        // random traffic
        for (int n = 0; n < 800; n++) begin
            step($urandom_range(0, 99) < 92, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 55, $urandom_range(0, 199) != 0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
